// File: rtl/clk_div_n_50.sv
// Runtime-programmable divide-by-N clock generator with exact 50% duty for even and odd N.
// Divisor and enable are only sampled at period boundaries (or while idle), so clk_out never glitches.
module clk_div_n_50 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         clk_out,
  output logic         tick,
  output logic         active,
  output logic [W-1:0] div_cur
);

  logic [W-1:0] cnt;
  logic [W-1:0] n_act;
  logic         p;
  logic         n;
  logic         load_ok;
  logic         boundary;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] half;

  assign load_ok  = en && (div >= W'(2));
  assign boundary = (cnt == n_act - W'(1));
  assign cnt_nxt  = cnt + W'(1);
  assign half     = n_act >> 1;

  // posedge phase: counter, divisor latch and high-phase flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      n_act <= '0;
      p     <= 1'b0;
      tick  <= 1'b0;
    end else if (n_act == '0) begin
      cnt <= '0;
      if (load_ok) begin
        n_act <= div;
        p     <= 1'b1;
        tick  <= 1'b1;
      end else begin
        p    <= 1'b0;
        tick <= 1'b0;
      end
    end else if (boundary) begin
      // The wrap is decided by compare, so N = 2^W-1 never relies on carry-out.
      cnt <= '0;
      if (load_ok) begin
        n_act <= div;
        p     <= 1'b1;
        tick  <= 1'b1;
      end else begin
        n_act <= '0;
        p     <= 1'b0;
        tick  <= 1'b0;
      end
    end else begin
      cnt  <= cnt_nxt;
      p    <= (cnt_nxt < half);
      tick <= 1'b0;
    end
  end

  // negedge phase: half-cycle stretch of the high phase for odd N
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= 1'b0;
    end else begin
      n <= p;
    end
  end

  // Select only on the registered divisor; it changes at boundaries where p and n are both low.
  assign clk_out = n_act[0] ? (p | n) : p;
  assign active  = (n_act != '0);
  assign div_cur = n_act;

endmodule
